// File: rtl/updi_uart_tx.sv
// UPDI-framed UART transmitter: start, 8 data bits LSB first, optional even parity, 1-2 stop bits.
// Drains the TX FIFO one byte per frame and drives the single-wire line level plus its output enable.
module updi_uart_tx #(
    parameter int UART_CLK_DIV = 1736,
    parameter int STOP_BITS    = 2,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic       inhibit,
    output logic       tx,
    output logic       tx_oe,
    output logic       busy,
    output logic       frame_done
);

    localparam int BW = $clog2(UART_CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(UART_CLK_DIV - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(UART_CLK_DIV - 2);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    state_t        state_r;
    logic [BW-1:0] baud_r;
    logic [2:0]    bit_r;
    logic [7:0]    shift_r;
    logic          parity_r;
    logic          tx_r;
    logic          tx_oe_r;
    logic          busy_r;
    logic          frame_done_r;
    logic          rd_en_s;
    logic          baud_end_s;

    // XOR of the data bits is exactly the bit that makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    assign rd_en_s    = (state_r == ST_IDLE) && !fifo_empty && !inhibit && !rst;
    assign baud_end_s = (baud_r == BAUD_LAST);

    assign fifo_rd_en = rd_en_s;
    assign tx         = tx_r;
    assign tx_oe      = tx_oe_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // Frame sequencer: state, baud/bit counters and registered line outputs move together
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            baud_r       <= '0;
            bit_r        <= 3'd0;
            shift_r      <= 8'd0;
            parity_r     <= 1'b0;
            tx_r         <= 1'b1;
            tx_oe_r      <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rd_en_s) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    shift_r  <= fifo_data;
                    parity_r <= even_parity(fifo_data);
                    baud_r   <= '0;
                    bit_r    <= 3'd0;
                    tx_r     <= 1'b0;
                    tx_oe_r  <= 1'b1;
                    state_r  <= ST_START;
                end
                ST_START: begin
                    if (baud_end_s) begin
                        baud_r  <= '0;
                        bit_r   <= 3'd0;
                        tx_r    <= shift_r[0];
                        state_r <= ST_DATA;
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_r <= '0;
                        if (bit_r == 3'd7) begin
                            bit_r <= 3'd0;
                            if (PARITY_EN != 0) begin
                                tx_r    <= parity_r;
                                state_r <= ST_PARITY;
                            end else begin
                                tx_r    <= 1'b1;
                                state_r <= ST_STOP;
                            end
                        end else begin
                            bit_r   <= bit_r + 3'd1;
                            shift_r <= shift_r >> 1;
                            tx_r    <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_end_s) begin
                        baud_r  <= '0;
                        bit_r   <= 3'd0;
                        tx_r    <= 1'b1;
                        state_r <= ST_STOP;
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_end_s) begin
                        baud_r <= '0;
                        if (bit_r == STOP_LAST) begin
                            bit_r   <= 3'd0;
                            tx_oe_r <= 1'b0;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            bit_r <= bit_r + 3'd1;
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1);
                        // registered pulse must land on the very last clk of the final stop bit
                        frame_done_r <= (bit_r == STOP_LAST) && (baud_r == BAUD_PRE);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    baud_r  <= '0;
                    bit_r   <= 3'd0;
                    tx_r    <= 1'b1;
                    tx_oe_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updi_uart_tx.sv
// Bench for updi_uart_tx: two instances (2 stop + parity, 1 stop no parity) checked every cycle
// against a frame-level waveform model fed from a queue-based FIFO model.
module tb_updi_uart_tx;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] fifo_data_a = 8'd0, fifo_data_b = 8'd0;
    logic       fifo_empty_a = 1'b1, fifo_empty_b = 1'b1;
    logic       inhibit_a = 1'b0, inhibit_b = 1'b0;
    logic       fifo_rd_en_a, tx_a, tx_oe_a, busy_a, frame_done_a;
    logic       fifo_rd_en_b, tx_b, tx_oe_b, busy_b, frame_done_b;

    always #5 clk = ~clk;

    updi_uart_tx #(.UART_CLK_DIV(DIV), .STOP_BITS(2), .PARITY_EN(1)) u_dut_a (
        .clk(clk), .rst(rst), .fifo_data(fifo_data_a), .fifo_empty(fifo_empty_a),
        .fifo_rd_en(fifo_rd_en_a), .inhibit(inhibit_a), .tx(tx_a), .tx_oe(tx_oe_a),
        .busy(busy_a), .frame_done(frame_done_a)
    );

    updi_uart_tx #(.UART_CLK_DIV(DIV), .STOP_BITS(1), .PARITY_EN(0)) u_dut_b (
        .clk(clk), .rst(rst), .fifo_data(fifo_data_b), .fifo_empty(fifo_empty_b),
        .fifo_rd_en(fifo_rd_en_b), .inhibit(inhibit_b), .tx(tx_b), .tx_oe(tx_oe_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] fq_a[$], fq_b[$];
    logic [3:0] eq_a[$], eq_b[$];
    logic [7:0] load_a = 8'd0, load_b = 8'd0;
    bit         load_pend_a = 1'b0, load_pend_b = 1'b0;
    bit         rst_req = 1'b1, inh_req_a = 1'b0;
    int         last_rd_a = 0, last_fd_a = 0, rd_gap_a = 0, rd_count_a = 0;
    int         last_rd_b = 0, last_fd_b = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected per-clk {tx, tx_oe, busy, frame_done} for one frame, starting at the LOAD cycle
    task automatic push_frame(input bit to_b, input logic [7:0] d);
        int         bits[$];
        int         stops;
        logic [3:0] e;
        stops = to_b ? 1 : 2;
        bits.push_back(0);
        for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
        if (!to_b) bits.push_back($countones(d) % 2);
        for (int i = 0; i < stops; i++) bits.push_back(1);
        if (to_b) eq_b.push_back(4'b1010); else eq_a.push_back(4'b1010);
        for (int b = 0; b < bits.size(); b++) begin
            for (int k = 0; k < DIV; k++) begin
                e = {bits[b][0], 1'b1, 1'b1, 1'((b == bits.size() - 1) && (k == DIV - 1))};
                if (to_b) eq_b.push_back(e); else eq_a.push_back(e);
            end
        end
    endtask

    task automatic cycle();
        logic [3:0] ea, eb;
        logic       exp_rd_a, exp_rd_b;
        @(posedge clk);
        #1;
        cyc++;
        rst          = rst_req;
        inhibit_a    = inh_req_a;
        fifo_empty_a = (fq_a.size() == 0);
        fifo_empty_b = (fq_b.size() == 0);
        fifo_data_a  = load_pend_a ? load_a : 8'($urandom);
        fifo_data_b  = load_pend_b ? load_b : 8'($urandom);
        #1;
        ea = (eq_a.size() > 0) ? eq_a.pop_front() : 4'b1000;
        eb = (eq_b.size() > 0) ? eq_b.pop_front() : 4'b1000;
        exp_rd_a = (ea == 4'b1000) && !fifo_empty_a && !inhibit_a && !rst;
        exp_rd_b = (eb == 4'b1000) && !fifo_empty_b && !inhibit_b && !rst;
        check("a_tx",    32'(tx_a),         32'(ea[3]));
        check("a_tx_oe", 32'(tx_oe_a),      32'(ea[2]));
        check("a_busy",  32'(busy_a),       32'(ea[1]));
        check("a_done",  32'(frame_done_a), 32'(ea[0]));
        check("a_rd_en", 32'(fifo_rd_en_a), 32'(exp_rd_a));
        check("b_tx",    32'(tx_b),         32'(eb[3]));
        check("b_tx_oe", 32'(tx_oe_b),      32'(eb[2]));
        check("b_busy",  32'(busy_b),       32'(eb[1]));
        check("b_done",  32'(frame_done_b), 32'(eb[0]));
        check("b_rd_en", 32'(fifo_rd_en_b), 32'(exp_rd_b));
        if (fifo_rd_en_a === 1'b1) begin
            if (rd_count_a > 0) rd_gap_a = cyc - last_rd_a;
            last_rd_a = cyc;
            rd_count_a++;
        end
        if (frame_done_a === 1'b1) last_fd_a = cyc;
        if (fifo_rd_en_b === 1'b1) last_rd_b = cyc;
        if (frame_done_b === 1'b1) last_fd_b = cyc;
        load_pend_a = 1'b0;
        load_pend_b = 1'b0;
        if (rst) begin
            eq_a.delete();
            eq_b.delete();
        end else begin
            if (exp_rd_a) begin
                load_a = fq_a.pop_front();
                load_pend_a = 1'b1;
                push_frame(1'b0, load_a);
            end
            if (exp_rd_b) begin
                load_b = fq_b.pop_front();
                load_pend_b = 1'b1;
                push_frame(1'b1, load_b);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int rd_before;

        rst_req = 1'b1;
        run(3);
        rst_req = 1'b0;
        run(3);

        // single 0x55 frame, frame_done 49 clk after rd_en
        fq_a.push_back(8'h55);
        run(60);
        check("t1_done_latency", 32'(last_fd_a - last_rd_a), 32'd49);

        // parity 1 and parity 0 data patterns
        fq_a.push_back(8'h07);
        run(55);
        fq_a.push_back(8'h00);
        run(55);

        // back-to-back frames
        rd_count_a = 0;
        fq_a.push_back(8'h55);
        fq_a.push_back(8'h80);
        run(110);
        check("t3_rd_count", 32'(rd_count_a), 32'd2);
        check("t3_rd_gap",   32'(rd_gap_a),   32'd50);

        // inhibit raised mid-frame with a second byte queued
        fq_a.push_back(8'($urandom));
        run(20);
        inh_req_a = 1'b1;
        fq_a.push_back(8'($urandom));
        rd_before = rd_count_a;
        run(60);
        check("t4_no_rd_inhibit", 32'(rd_count_a), 32'(rd_before));
        inh_req_a = 1'b0;
        cycle();
        check("t4_rd_on_release", 32'(fifo_rd_en_a), 32'd1);
        run(55);

        // reset during data bit 3, then a fresh byte must go out cleanly
        fq_a.push_back(8'hA5);
        fq_a.push_back(8'h3C);
        run(19);
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        cycle();
        check("t5_idle_tx",   32'(tx_a),    32'd1);
        check("t5_idle_oe",   32'(tx_oe_a), 32'd0);
        run(60);

        // empty FIFO for 1000 clk: no reads
        rd_before = rd_count_a;
        run(1000);
        check("t6_no_rd_empty", 32'(rd_count_a), 32'(rd_before));

        // 1 stop, no parity variant: 40-clk frame
        fq_b.push_back(8'h55);
        run(50);
        check("t6_b_done_latency", 32'(last_fd_b - last_rd_b), 32'd41);

        // randomized traffic with random inhibit windows on both instances
        for (int it = 0; it < 15; it++) begin
            fq_a.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) fq_a.push_back(8'($urandom));
            fq_b.push_back(8'($urandom));
            inh_req_a = ($urandom_range(0, 3) == 0);
            run(int'($urandom_range(30, 70)));
        end
        inh_req_a = 1'b0;
        run(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/updi_uart_tx.md
Name: updi_uart_tx

Overview:
UPDI-framed UART transmitter. It drains bytes from the PHY's TX FIFO read side and serialises them onto the single-wire UPDI line. Frame format: start, 8 data bits LSB first, even parity, 2 stop bits. It sits inside updi_phy, downstream of the TX FIFO that the programmer writes. It supplies the data level and output-enable for the line tristate, and yields to the double-break generator via an inhibit input.

Parameters:
UART_CLK_DIV, 1736, clk cycles per bit (100 MHz / 57600); legal values >= 2.
STOP_BITS, 2, number of stop bits; legal values 1 or 2.
PARITY_EN, 1, 1 = even parity bit inserted, 0 = no parity bit.

Ports:
clk  input  1  system clock
rst  input  1  reset
fifo_data  input  8  TX FIFO read data; valid the cycle after fifo_rd_en
fifo_empty  input  1  TX FIFO empty flag
fifo_rd_en  output  1  TX FIFO read strobe, one cycle per byte
inhibit  input  1  high = do not start a new frame (double break in progress)
tx  output  1  serial line level, idle high
tx_oe  output  1  line drive enable for the tristate buffer
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse on the last clk of the final stop bit

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous and active-high, named rst.
- Reset values: tx=1, tx_oe=0, busy=0, frame_done=0, fifo_rd_en=0. Baud counter and bit counter are 0.
- fifo_rd_en = (state==IDLE) && !fifo_empty && !inhibit && !rst. It is combinational and asserted for exactly one cycle per byte.
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE: if fifo_rd_en is asserted, go to LOAD.
- LOAD (1 clk): capture fifo_data into the shift register. Compute parity = XOR of the 8 bits, which gives even parity. Go to START.
- START: 1 bit period, then DATA.
- DATA: 8 bit periods, shift register LSB first, bit counter 0..7. Then PARITY if PARITY_EN, else STOP.
- PARITY: 1 bit period, then STOP.
- STOP: STOP_BITS bit periods, then IDLE.
- Bit period: exactly UART_CLK_DIV clk cycles. The baud counter counts 0..UART_CLK_DIV-1 and is reset to 0 on entry to START. It does not free-run, so latency is deterministic.
- tx and tx_oe are registered and change on the same edge as the state transition.
  - tx = 0 in START, data bit in DATA, parity in PARITY, 1 otherwise.
  - tx_oe = 1 in START, DATA, PARITY and STOP only.
- Latency: rd_en in cycle N, LOAD in N+1, first start-bit cycle (tx=0, tx_oe=1) in N+2.
- Frame length: (1+8+PARITY_EN+STOP_BITS)*UART_CLK_DIV clk. Default is 12*1736.
- frame_done: asserted in the final clk of the last stop bit. IDLE follows on the next cycle.
- Back-to-back frames: the FIFO is re-checked in IDLE. Consecutive frames are separated by exactly 2 clk (IDLE, LOAD) with tx=1 and tx_oe=0.
- inhibit:
  - Sampled only in IDLE.
  - Asserting it mid-frame does not truncate the frame.
  - While inhibit=1 in IDLE there is no rd_en, regardless of fifo_empty.
  - rd_en fires in the first IDLE cycle with inhibit=0 and fifo_empty=0.
- fifo_empty rising while in LOAD or later is ignored; the captured byte is transmitted.
- Reset mid-frame: on the next edge the block is in IDLE with tx=1 and tx_oe=0. The in-flight byte is discarded and not re-read. No rd_en while rst=1.
- The transmitter never reads the RX path. Echo suppression is the receiver's responsibility, using tx_oe.

Test Plan:
1. UART_CLK_DIV=4, push 0x55 -> rd_en at N. tx=0 for N+2..N+5, then data 1,0,1,0,1,0,1,0 (4 clk each), parity 0, stop 1,1. tx_oe high for 48 clk. frame_done at N+49. busy low at N+50.
2. DIV=4, push 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1. Push 0x00 -> parity 0.
3. DIV=4, push 0x55 then 0x80 back-to-back -> two rd_en pulses 50 clk apart. Frames separated by exactly 2 clk of tx=1, tx_oe=0. Second frame data ends with bit7=1, parity 1.
4. inhibit=1 from mid-frame of byte A with byte B queued -> A completes all 48 clk. No rd_en while inhibit=1. Deassert inhibit -> rd_en in that same cycle, start bit 2 clk later.
5. rst pulsed during DATA bit 3 -> next cycle tx=1, tx_oe=0, busy=0. After release with FIFO non-empty, a new byte is read and its start bit lasts a full 4 clk.
6. fifo_empty held 1 for 1000 clk -> rd_en never asserted, tx=1, tx_oe=0. Repeat test 1 with STOP_BITS=1, PARITY_EN=0 -> 40-clk frame.
